// File: rtl/bi_link_pkg.sv
// Shared types and helpers for the bidirectional link direction controller.
// Side/state encodings plus parameter lower bounds used by the elaboration checks.
package bi_link_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_OWN1, ST_OWN2, ST_TURN} link_state_t;
    typedef enum logic {SIDE1, SIDE2} link_side_t;

    localparam int HOLD_MAX_MIN    = 1;
    localparam int TURN_CYCLES_MIN = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic link_side_t other_side(input link_side_t s);
        if (s == SIDE1) return SIDE2;
        return SIDE1;
    endfunction

    function automatic link_state_t own_state(input link_side_t s);
        if (s == SIDE1) return ST_OWN1;
        return ST_OWN2;
    endfunction

    function automatic logic side_req(input link_side_t s, input logic r1, input logic r2);
        return (s == SIDE1) ? r1 : r2;
    endfunction

endpackage

// File: rtl/bi_link_ctrl.sv
// Direction controller for one bidirectional router-to-router link: grants one side at a
// time, inserts a turnaround bubble on every direction change and bounds hold time.
module bi_link_ctrl
    import bi_link_pkg::*;
#(
    parameter int HOLD_MAX    = 8,
    parameter int TURN_CYCLES = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req1,
    input  logic             req2,
    output logic             inout_select1,
    output logic             inout_select2,
    output logic             turning,
    output logic [CNT_W-1:0] switch_cnt
);

    if (HOLD_MAX < HOLD_MAX_MIN) begin : g_bad_hold_max
        $error("bi_link_ctrl: HOLD_MAX must be at least 1");
    end
    if (TURN_CYCLES < TURN_CYCLES_MIN) begin : g_bad_turn_cycles
        $error("bi_link_ctrl: TURN_CYCLES must be at least 1");
    end

    // Hold and turn counting never overlap, so one register serves both.
    localparam int CW = $clog2(max_int(HOLD_MAX, TURN_CYCLES) + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);
    localparam logic [CW-1:0] TURN_LAST = CW'(TURN_CYCLES - 1);

    link_state_t state, state_nxt;
    link_side_t  last_owner, last_nxt;
    link_side_t  target, target_nxt;
    link_side_t  own_side, alt_side;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          own_req, oth_req;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nxt  = state;
        last_nxt   = last_owner;
        target_nxt = target;
        cnt_nxt    = cnt;
        own_side   = (state == ST_OWN2) ? SIDE2 : SIDE1;
        alt_side   = other_side(target);
        own_req    = side_req(own_side, req1, req2);
        oth_req    = side_req(other_side(own_side), req1, req2);

        case (state)
            ST_IDLE: begin
                if (req1 && (!req2 || last_owner == SIDE2)) begin
                    state_nxt = ST_OWN1;
                    last_nxt  = SIDE1;
                    cnt_nxt   = '0;
                end else if (req2) begin
                    state_nxt = ST_OWN2;
                    last_nxt  = SIDE2;
                    cnt_nxt   = '0;
                end
            end
            ST_OWN1, ST_OWN2: begin
                if (!own_req && !oth_req) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (oth_req && (!own_req || cnt == HOLD_LAST)) begin
                    state_nxt  = ST_TURN;
                    target_nxt = other_side(own_side);
                    cnt_nxt    = '0;
                end else if (cnt != HOLD_LAST) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_TURN: begin
                if (cnt == TURN_LAST) begin
                    cnt_nxt = '0;
                    // A withdrawn target hands straight to the other side without a second bubble.
                    if (side_req(target, req1, req2)) begin
                        state_nxt = own_state(target);
                        last_nxt  = target;
                    end else if (side_req(alt_side, req1, req2)) begin
                        state_nxt = own_state(alt_side);
                        last_nxt  = alt_side;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            last_owner    <= SIDE2;
            target        <= SIDE1;
            cnt           <= '0;
            inout_select1 <= 1'b0;
            inout_select2 <= 1'b0;
            turning       <= 1'b0;
            switch_cnt    <= '0;
        end else begin
            state         <= state_nxt;
            last_owner    <= last_nxt;
            target        <= target_nxt;
            cnt           <= cnt_nxt;
            inout_select1 <= (state_nxt == ST_OWN1);
            inout_select2 <= (state_nxt == ST_OWN2);
            turning       <= (state_nxt == ST_TURN);
            if (state_nxt == ST_TURN && state != ST_TURN && switch_cnt != '1) begin
                switch_cnt <= switch_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bi_link_ctrl.sv
// Bench for bi_link_ctrl: table-driven vectors through a scoreboard queue on the main
// instance, plus a hand-written alternation/saturation sequence on a narrow-counter instance.
module tb_bi_link_ctrl;

    typedef struct packed {
        logic        rst;
        logic        r1;
        logic        r2;
        logic        s1;
        logic        s2;
        logic        t;
        logic [15:0] sw;
    } vec_t;

    typedef struct packed {
        logic        s1;
        logic        s2;
        logic        t;
        logic [15:0] sw;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req1 = 1'b0;
    logic        req2 = 1'b0;
    logic        req1b = 1'b0;
    logic        req2b = 1'b0;
    logic        sel1, sel2, turn;
    logic [15:0] sw;
    logic        sel1b, sel2b, turnb;
    logic [1:0]  swb;

    int n_checks = 0;
    int n_errors = 0;

    vec_t vecs[$];
    exp_t exp_q[$];

    always #5 clk = ~clk;

    bi_link_ctrl #(.HOLD_MAX(4), .TURN_CYCLES(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req1(req1), .req2(req2),
        .inout_select1(sel1), .inout_select2(sel2), .turning(turn), .switch_cnt(sw)
    );

    bi_link_ctrl #(.HOLD_MAX(1), .TURN_CYCLES(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .req1(req1b), .req2(req2b),
        .inout_select1(sel1b), .inout_select2(sel2b), .turning(turnb), .switch_cnt(swb)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic a, input logic b, input logic s1,
                                input logic s2, input logic t, input int swv);
        vecs.push_back('{rst: r, r1: a, r2: b, s1: s1, s2: s2, t: t, sw: 16'(swv)});
    endfunction

    initial begin
        exp_t e;

        // Reset held with both requesting, then contention from release.
        add(1, 1, 1, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0);
        for (int c = 1; c <= 20; c++) begin
            int ph;
            ph = (c - 1) % 10;
            add(0, 1, 1, ph < 4, ph >= 5 && ph <= 8, ph == 4 || ph == 9, c / 5);
        end
        add(0, 0, 0, 0, 0, 0, 4);
        // Single requester after a fresh reset.
        add(1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1, 0, 0, 0);
        add(0, 1, 0, 1, 0, 0, 0);
        add(0, 1, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        // Handover on the same edge.
        add(0, 1, 0, 1, 0, 0, 0);
        add(0, 0, 1, 0, 0, 1, 1);
        add(0, 0, 1, 0, 1, 0, 1);
        // Target withdraws during TURN, then both withdraw.
        add(0, 0, 0, 0, 0, 0, 1);
        add(0, 1, 0, 1, 0, 0, 1);
        add(0, 0, 1, 0, 0, 1, 2);
        add(0, 1, 0, 1, 0, 0, 2);
        add(0, 0, 1, 0, 0, 1, 3);
        add(0, 0, 0, 0, 0, 0, 3);
        // Reset during TURN.
        add(0, 1, 0, 1, 0, 0, 3);
        add(0, 0, 1, 0, 0, 1, 4);
        add(1, 0, 1, 0, 0, 0, 0);
        // Uncontested hold past HOLD_MAX, then immediate preemption.
        add(0, 0, 1, 0, 1, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0);
        add(0, 1, 1, 0, 0, 1, 1);
        add(0, 1, 1, 1, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst  = vecs[i].rst;
            req1 = vecs[i].r1;
            req2 = vecs[i].r2;
            exp_q.push_back('{s1: vecs[i].s1, s2: vecs[i].s2, t: vecs[i].t, sw: vecs[i].sw});
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check($sformatf("v%0d.sel1", i), 32'(sel1), 32'(e.s1));
            check($sformatf("v%0d.sel2", i), 32'(sel2), 32'(e.s2));
            check($sformatf("v%0d.turning", i), 32'(turn), 32'(e.t));
            check($sformatf("v%0d.switch_cnt", i), 32'(sw), 32'(e.sw));
            check($sformatf("v%0d.no_overlap", i), 32'(sel1 & sel2), 32'd0);
        end

        // HOLD_MAX=1, TURN_CYCLES=2, 2-bit counter: alternating ownership, saturating count.
        @(negedge clk);
        rst   = 1'b1;
        req1  = 1'b0;
        req2  = 1'b0;
        req1b = 1'b1;
        req2b = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            logic own;
            int   swe;
            @(posedge clk);
            #1;
            own = (c % 3 == 1);
            swe = ((c + 1) / 3 > 3) ? 3 : (c + 1) / 3;
            check($sformatf("sat%0d.sel1", c), 32'(sel1b), 32'(own && ((c / 3) % 2 == 0)));
            check($sformatf("sat%0d.sel2", c), 32'(sel2b), 32'(own && ((c / 3) % 2 == 1)));
            check($sformatf("sat%0d.turning", c), 32'(turnb), 32'(!own));
            check($sformatf("sat%0d.switch_cnt", c), 32'(swb), 32'(swe));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
